// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Brief    : Shared constants, state encoding and ns/us-to-cycle helpers for
//            the WS2812/SK6812 strip driver.
// Revision : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    localparam int LED_BITS_RGB  = 24;
    localparam int LED_BITS_RGBW = 32;

    // Explicitly sized state encoding for the strip sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    // Whole clock cycles contained in a duration given in nanoseconds (truncating)
    function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns) / longint'(1000000000));
    endfunction

    // Whole clock cycles contained in a duration given in microseconds (truncating)
    function automatic int us_to_cyc(input longint clk_hz, input longint us);
        return int'((clk_hz * us) / longint'(1000000));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_bit_encoder
// Brief    : Generates one WS2812 bit waveform per go strobe: high for T0H or
//            T1H cycles, low for the rest of the BIT_CYC period. A go strobe
//            coinciding with bit_done chains the next bit with no gap.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_bit_encoder #(
    parameter int T0H_CYC = 4,
    parameter int T1H_CYC = 9,
    parameter int BIT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic bit_val,
    output logic data,
    output logic bit_done
);

    localparam int                c_BC_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(BIT_CYC - 1);
    localparam logic [c_BC_W-1:0] c_T0H     = c_BC_W'(T0H_CYC);
    localparam logic [c_BC_W-1:0] c_T1H     = c_BC_W'(T1H_CYC);

    logic              r_active;
    logic [c_BC_W-1:0] r_bc;
    logic [c_BC_W-1:0] w_thr;

    // Bit-period counter: restarts on go, stops after the last cycle of a bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_bc     <= '0;
        end else if (go) begin
            r_active <= 1'b1;
            r_bc     <= '0;
        end else if (r_active) begin
            if (r_bc == c_BC_LAST) begin
                r_active <= 1'b0;
                r_bc     <= '0;
            end else begin
                r_bc <= r_bc + c_BC_W'(1);
            end
        end
    end

    // High-time threshold follows the bit currently at the head of the shifter
    always_comb begin
        w_thr    = bit_val ? c_T1H : c_T0H;
        data     = r_active && (r_bc < w_thr);
        bit_done = r_active && (r_bc == c_BC_LAST);
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_strip.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_strip
// Brief    : Parametrised WS2812/SK6812 strip driver. Holds a per-LED
//            framebuffer, serialises it onto one data line in G,R,B(,W)
//            order with a latch gap before every frame, one-shot or
//            continuous refresh.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_strip
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int LED_BITS     = 24,
    parameter int CLK_HZ       = 12000000,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int BIT_NS       = 1250,
    parameter int LATCH_US     = 300,
    parameter int AUTO_REFRESH = 1,
    localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LED_BITS-1:0] rgb_data,
    input  logic [IDX_W-1:0]    led_num,
    input  logic                write,
    input  logic                start,
    output logic                data,
    output logic                busy,
    output logic                frame_done
);

    localparam int c_T0H_CYC   = ns_to_cyc(CLK_HZ, T0H_NS);
    localparam int c_T1H_CYC   = ns_to_cyc(CLK_HZ, T1H_NS);
    localparam int c_BIT_CYC   = ns_to_cyc(CLK_HZ, BIT_NS);
    localparam int c_LATCH_CYC = us_to_cyc(CLK_HZ, LATCH_US);

    localparam int                     c_LATCH_W    = (c_LATCH_CYC > 1) ? $clog2(c_LATCH_CYC) : 1;
    localparam logic [c_LATCH_W-1:0]   c_LATCH_LAST = c_LATCH_W'(c_LATCH_CYC - 1);
    localparam int                     c_BIT_IDX_W  = $clog2(LED_BITS);
    localparam logic [c_BIT_IDX_W-1:0] c_BIT_LAST   = c_BIT_IDX_W'(LED_BITS - 1);
    localparam logic [IDX_W-1:0]       c_LED_LAST   = IDX_W'(NUM_LEDS - 1);
    localparam int                     c_IDXP1_W    = IDX_W + 1;
    localparam logic [IDX_W:0]         c_NUM_LEDS   = c_IDXP1_W'(NUM_LEDS);

    // Elaboration-time parameter sanity
    if (LED_BITS != LED_BITS_RGB && LED_BITS != LED_BITS_RGBW) begin : g_bad_led_bits
        $error("ws2812_strip: LED_BITS must be 24 or 32");
    end
    if (!(c_T0H_CYC >= 1 && c_T0H_CYC < c_T1H_CYC && c_T1H_CYC < c_BIT_CYC)) begin : g_bad_timing
        $error("ws2812_strip: need 1 <= T0H_CYC < T1H_CYC < BIT_CYC");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_num_leds
        $error("ws2812_strip: NUM_LEDS must be 1..256");
    end
    if (c_LATCH_CYC < 1) begin : g_bad_latch
        $error("ws2812_strip: LATCH_CYC must be at least 1");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LED_BITS-1:0]     r_fb [NUM_LEDS];
    logic [c_LATCH_W-1:0]    r_latch_cnt;
    logic [IDX_W-1:0]        r_led_idx;
    logic [c_BIT_IDX_W-1:0]  r_bit_idx;
    logic [LED_BITS-1:0]     r_shift;
    logic                    r_frame_done;

    logic [IDX_W-1:0]        w_cap_idx;
    logic [LED_BITS-1:0]     w_cap_raw;
    logic [LED_BITS-1:0]     w_cap_wire;
    logic                    w_bit_done;
    logic                    w_last_bit;
    logic                    w_last_led;
    logic                    w_latch_end;
    logic                    w_frame_end;
    logic                    w_go;

    // Framebuffer: out-of-range indices are dropped, writes accepted in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_fb[i] <= '0;
            end
        end else if (write && ({1'b0, led_num} < c_NUM_LEDS)) begin
            r_fb[led_num] <= rgb_data;
        end
    end

    // Pixel capture: first pixel at the end of the latch gap, next pixel otherwise;
    // wire order is G,R then the remaining B(,W) bytes
    always_comb begin
        w_cap_idx  = (r_state == SEND) ? (r_led_idx + IDX_W'(1)) : '0;
        w_cap_raw  = ({1'b0, w_cap_idx} < c_NUM_LEDS) ? r_fb[w_cap_idx] : '0;
        w_cap_wire = {w_cap_raw[LED_BITS-9 -: 8], w_cap_raw[LED_BITS-1 -: 8], w_cap_raw[LED_BITS-17:0]};
    end

    // Sequencing events shared by the FSM and the datapath
    always_comb begin
        w_last_bit  = (r_bit_idx == c_BIT_LAST);
        w_last_led  = (r_led_idx == c_LED_LAST);
        w_latch_end = (r_state == LATCH) && (r_latch_cnt == c_LATCH_LAST);
        w_frame_end = (r_state == SEND) && w_bit_done && w_last_bit && w_last_led;
        w_go        = w_latch_end || ((r_state == SEND) && w_bit_done && !w_frame_end);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start only matters in one-shot mode while idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if ((AUTO_REFRESH != 0) || start) w_state_nxt = LATCH;
            LATCH:   if (w_latch_end) w_state_nxt = SEND;
            SEND:    if (w_frame_end) w_state_nxt = (AUTO_REFRESH != 0) ? LATCH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch counter, pixel/bit indices, shift register and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latch_cnt  <= '0;
            r_led_idx    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if ((r_state == LATCH) && !w_latch_end) begin
                r_latch_cnt <= r_latch_cnt + c_LATCH_W'(1);
            end else begin
                r_latch_cnt <= '0;
            end
            if (w_latch_end) begin
                r_led_idx <= '0;
                r_bit_idx <= '0;
                r_shift   <= w_cap_wire;
            end else if ((r_state == SEND) && w_bit_done) begin
                if (w_last_bit) begin
                    r_bit_idx <= '0;
                    if (!w_last_led) begin
                        r_led_idx <= r_led_idx + IDX_W'(1);
                        r_shift   <= w_cap_wire;
                    end
                end else begin
                    r_bit_idx <= r_bit_idx + c_BIT_IDX_W'(1);
                    r_shift   <= {r_shift[LED_BITS-2:0], 1'b0};
                end
            end
        end
    end

    ws2812_bit_encoder #(
        .T0H_CYC (c_T0H_CYC),
        .T1H_CYC (c_T1H_CYC),
        .BIT_CYC (c_BIT_CYC)
    ) u_bit_encoder (
        .clk      (clk),
        .reset    (reset),
        .go       (w_go),
        .bit_val  (r_shift[LED_BITS-1]),
        .data     (data),
        .bit_done (w_bit_done)
    );

    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_strip.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_strip
// Brief    : Directed self-checking bench for ws2812_strip: one-shot RGB,
//            auto-refresh RGB (3 LEDs) and one-shot RGBW instances at 12 MHz.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_strip;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst, ar_rst;
    logic [23:0] os_rgb;  logic [1:0] os_led;  logic os_write, os_start;
    logic        os_data, os_busy, os_done;
    logic [23:0] ar_rgb;  logic [1:0] ar_led;  logic ar_write;
    logic        ar_data, ar_busy, ar_done;
    logic [31:0] w_rgb;   logic [1:0] w_led;   logic w_write, w_start;
    logic        w_data, w_busy, w_done;

    ws2812_strip #(.NUM_LEDS(4), .LED_BITS(24), .AUTO_REFRESH(0)) u_os (
        .clk(clk), .reset(rst), .rgb_data(os_rgb), .led_num(os_led), .write(os_write),
        .start(os_start), .data(os_data), .busy(os_busy), .frame_done(os_done));

    ws2812_strip #(.NUM_LEDS(3), .LED_BITS(24), .AUTO_REFRESH(1)) u_ar (
        .clk(clk), .reset(ar_rst), .rgb_data(ar_rgb), .led_num(ar_led), .write(ar_write),
        .start(1'b0), .data(ar_data), .busy(ar_busy), .frame_done(ar_done));

    ws2812_strip #(.NUM_LEDS(4), .LED_BITS(32), .AUTO_REFRESH(0)) u_w (
        .clk(clk), .reset(rst), .rgb_data(w_rgb), .led_num(w_led), .write(w_write),
        .start(w_start), .data(w_data), .busy(w_busy), .frame_done(w_done));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        case (sel)
            0:       return os_data;
            1:       return ar_data;
            default: return w_data;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return os_done;
            1:       return ar_done;
            default: return w_done;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return os_busy;
            1:       return ar_busy;
            default: return w_busy;
        endcase
    endfunction

    logic [127:0] cap_bits;
    int cap_first, cap_done, cap_bad;
    logic cap_done_busy;

    // Decode one frame: 9 high cycles = 1, 4 high = 0, every bit 15 cycles
    task automatic capture(input int sel, input int nbits);
        int guard, h, l;
        cap_bits = '0; cap_bad = 0; cap_first = 0; cap_done = 0; cap_done_busy = 1'bx;
        guard = 0;
        while (line_of(sel) !== 1'b1 && guard < 8000) begin @(negedge clk); guard++; end
        chk("first_high_seen", guard < 8000, 1);
        if (guard >= 8000) return;
        cap_first = cyc;
        for (int b = 0; b < nbits; b++) begin
            h = 0;
            while (line_of(sel) === 1'b1 && h < 40) begin @(negedge clk); h++; end
            if (h != 9 && h != 4) cap_bad++;
            cap_bits = {cap_bits[126:0], (h == 9)};
            if (b < nbits - 1) begin
                l = 0;
                while (line_of(sel) !== 1'b1 && l < 40) begin @(negedge clk); l++; end
                if (h + l != 15) cap_bad++;
            end
        end
        guard = 0;
        while (done_of(sel) !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        cap_done      = cyc;
        cap_done_busy = busy_of(sel);
    endtask

    task automatic wait_done(input int sel);
        int g;
        g = 0;
        while (done_of(sel) !== 1'b1 && g < 10000) begin @(negedge clk); g++; end
        chk("frame_done_seen", g < 10000, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, highs, g;
        rst = 1'b1; ar_rst = 1'b1;
        os_rgb = '0; os_led = '0; os_write = 1'b0; os_start = 1'b0;
        ar_rgb = '0; ar_led = '0; ar_write = 1'b0;
        w_rgb  = '0; w_led  = '0; w_write  = 1'b0; w_start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_os_outs", {os_data, os_busy, os_done}, 0);
        chk("rst_ar_outs", {ar_data, ar_busy, ar_done}, 0);
        chk("rst_w_outs",  {w_data, w_busy, w_done}, 0);
        rst = 1'b0; ar_rst = 1'b0;
        @(negedge clk);
        chk("os_idle_busy", os_busy, 0);
        chk("ar_auto_latch_busy", ar_busy, 1);

        // Auto refresh: pixel 2 = blue AA, led_num 3 is beyond the strip
        ar_write = 1'b1; ar_led = 2'd2; ar_rgb = 24'h0000AA;
        @(negedge clk); ar_led = 2'd3; ar_rgb = 24'hFFFFFF;
        @(negedge clk); ar_write = 1'b0;
        wait_done(1);
        t = cyc;
        capture(1, 72);
        chk("ar_gap1", cap_first - t, 3600);
        chk("ar_frame1", cap_bits, 128'h0000AA);
        chk("ar_len1", cap_done - cap_first, 1080);
        chk("ar_timing1", cap_bad, 0);
        t = cap_done;
        capture(1, 72);
        chk("ar_gap2", cap_first - t, 3600);
        chk("ar_frame2", cap_bits, 128'h0000AA);
        chk("ar_len2", cap_done - cap_first, 1080);

        // One-shot: red in pixel 0, extra start during the latch gap
        os_write = 1'b1; os_led = 2'd0; os_rgb = 24'hFF0000;
        @(negedge clk); os_write = 1'b0;
        os_start = 1'b1;
        @(negedge clk); os_start = 1'b0;
        t = cyc;
        chk("os_busy_rise", os_busy, 1);
        fork
            capture(0, 96);
            begin
                repeat (100) @(negedge clk);
                os_start = 1'b1;
                @(negedge clk); os_start = 1'b0;
            end
        join
        chk("os_latency", cap_first - t, 3600);
        chk("os_frame1", cap_bits, {32'h0, 24'h00FF00, 72'h0});
        chk("os_len1", cap_done - cap_first, 1440);
        chk("os_timing1", cap_bad, 0);
        chk("os_busy_at_done", cap_done_busy, 0);
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (os_data !== 1'b0) highs++;
        end
        chk("os_quiet_after", highs, 0);
        chk("os_idle_after", os_busy, 0);

        // Mid-frame writes while pixel 1 is on the wire
        os_start = 1'b1;
        @(negedge clk); os_start = 1'b0;
        fork
            capture(0, 96);
            begin
                repeat (3600 + 360 + 30) @(negedge clk);
                os_write = 1'b1; os_led = 2'd3; os_rgb = 24'h0000AA;
                @(negedge clk); os_led = 2'd0; os_rgb = 24'h123456;
                @(negedge clk); os_write = 1'b0;
            end
        join
        chk("os_frame2", cap_bits, {32'h0, 24'h00FF00, 48'h0, 24'h0000AA});
        os_start = 1'b1;
        @(negedge clk); os_start = 1'b0;
        capture(0, 96);
        chk("os_frame3", cap_bits, {32'h0, 24'h341256, 48'h0, 24'h0000AA});

        // RGBW: W byte goes out last
        w_write = 1'b1; w_led = 2'd0; w_rgb = 32'h11223344;
        @(negedge clk); w_led = 2'd3; w_rgb = 32'h000000FF;
        @(negedge clk); w_write = 1'b0;
        w_start = 1'b1;
        @(negedge clk); w_start = 1'b0;
        capture(2, 128);
        chk("w_frame", cap_bits, {32'h22113344, 64'h0, 32'h000000FF});
        chk("w_len", cap_done - cap_first, 1920);
        chk("w_timing", cap_bad, 0);

        // Asynchronous reset in bit 7 of pixel 0 on the auto-refresh strip
        wait_done(1);
        g = 0;
        while (ar_data !== 1'b1 && g < 8000) begin @(negedge clk); g++; end
        chk("ar_sync_high", g < 8000, 1);
        repeat (7 * 15 + 2) @(negedge clk);
        chk("ar_mid_bit_high", ar_data, 1);
        #1 ar_rst = 1'b1;
        #1;
        chk("ar_rst_data", ar_data, 0);
        chk("ar_rst_busy", ar_busy, 0);
        @(negedge clk); ar_rst = 1'b0;
        t = cyc;
        g = 0;
        while (ar_data !== 1'b1 && g < 8000) begin @(negedge clk); g++; end
        chk("ar_post_rst_gap", (cyc - t >= 3600) && (cyc - t <= 3601), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
